// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle RV32I control unit:
// opcodes, FSM state encodings and register-file write-data select codes.
package uc_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] RFSEL_MEM   = 3'b000;
  localparam logic [2:0] RFSEL_ALU   = 3'b001;
  localparam logic [2:0] RFSEL_PC4   = 3'b010;
  localparam logic [2:0] RFSEL_ADDER = 3'b011;
  localparam logic [2:0] RFSEL_IMM   = 3'b100;

  // FETCH must stay 0: state_dbg reads as FETCH while reset forces outputs low
  typedef enum logic [4:0] {
    FETCH     = 5'd0,
    DECODE    = 5'd1,
    EX_ALU    = 5'd2,
    EX_ALUI   = 5'd3,
    EX_LUI    = 5'd4,
    EX_AUIPC  = 5'd5,
    EX_LOAD   = 5'd6,
    EX_STORE  = 5'd7,
    EX_JAL    = 5'd8,
    EX_JALR   = 5'd9,
    EX_BRANCH = 5'd10,
    WB_ALU    = 5'd11,
    WB_ALUI   = 5'd12,
    WB_LUI    = 5'd13,
    WB_AUIPC  = 5'd14,
    WB_JAL    = 5'd15,
    WB_JALR   = 5'd16,
    WB_BRANCH = 5'd17,
    MEM_LOAD  = 5'd18,
    MEM_STORE = 5'd19,
    TRAP      = 5'd20
  } state_e;

  function automatic logic is_mem_state(input state_e s);
    return (s == FETCH) || (s == MEM_LOAD) || (s == MEM_STORE);
  endfunction

endpackage

// File: rtl/uc_mc_handshake_if.sv
// Control-unit bundle: IR opcode and memory handshake in, datapath controls out.
interface uc_mc_handshake_if;
  import uc_pkg::*;

  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       WE_RF;
  logic       WE_MEM;
  logic [2:0] RF_din_sel;
  logic       ULA_din2_sel;
  logic       addr_sel;
  logic       load_pc;
  logic       load_ir;
  logic       branch;
  logic       pc_next_sel;
  logic       pc_adder_sel;
  logic       illegal_instr;
  logic       timeout_err;
  logic [4:0] state_dbg;

  modport master (
    input  opcode, mem_ready,
    output mem_req, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, addr_sel,
           load_pc, load_ir, branch, pc_next_sel, pc_adder_sel,
           illegal_instr, timeout_err, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, addr_sel,
           load_pc, load_ir, branch, pc_next_sel, pc_adder_sel,
           illegal_instr, timeout_err, state_dbg
  );
endinterface

// File: rtl/uc_mem_watchdog.sv
// Counts consecutive memory wait cycles; expire flags the last permitted wait.
module uc_mem_watchdog
  import uc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic waiting,
  output logic expire
);

  if (MEM_TIMEOUT > 0) begin : g_wd
    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (waiting) begin
        cnt_d = cnt_q + TO_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // waiting already excludes mem_ready, so a completing access never expires
    assign expire = waiting && (cnt_q == TO_W'(MEM_TIMEOUT - 1));
  end else begin : g_off
    logic unused_s;
    assign unused_s = &{1'b0, clk, reset, clr, waiting};
    assign expire   = 1'b0;
  end

endmodule

// File: rtl/uc_mc_handshake.sv
// Multicycle RV32I control FSM with memory ready/request handshake,
// illegal-opcode and memory-timeout traps, and an optional fast ALU path.
module uc_mc_handshake
  import uc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int FAST_ALU    = 0,
  parameter int TO_W        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input  logic               clk,
  input  logic               reset,
  uc_mc_handshake_if.master  bus
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       mem_req_s, we_rf_s, we_mem_s, ula2_s, addr_sel_s;
  logic       load_pc_s, load_ir_s, branch_s, pc_next_s, pc_adder_s;
  logic [2:0] rf_sel_s;
  logic       set_illegal_s, expire_s, wd_clr_s, wd_wait_s;

  assign wd_wait_s = is_mem_state(state_q) && !bus.mem_ready;
  assign wd_clr_s  = bus.mem_ready || (is_mem_state(state_d) && (state_d != state_q));

  uc_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr_s),
    .waiting (wd_wait_s),
    .expire  (expire_s)
  );

  always_comb begin
    state_d       = state_q;
    set_illegal_s = 1'b0;
    mem_req_s     = 1'b0;
    we_rf_s       = 1'b0;
    we_mem_s      = 1'b0;
    ula2_s        = 1'b0;
    addr_sel_s    = 1'b0;
    load_pc_s     = 1'b0;
    load_ir_s     = 1'b0;
    branch_s      = 1'b0;
    pc_next_s     = 1'b0;
    pc_adder_s    = 1'b0;
    rf_sel_s      = RFSEL_MEM;
    case (state_q)
      FETCH: begin
        mem_req_s  = 1'b1;
        addr_sel_s = 1'b1;
        load_ir_s  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
        else if (expire_s) state_d = TRAP;
        else               state_d = FETCH;
      end
      DECODE: begin
        case (bus.opcode)
          OPC_OP:     state_d = (FAST_ALU != 0) ? WB_ALU   : EX_ALU;
          OPC_OPIMM:  state_d = (FAST_ALU != 0) ? WB_ALUI  : EX_ALUI;
          OPC_LUI:    state_d = (FAST_ALU != 0) ? WB_LUI   : EX_LUI;
          OPC_AUIPC:  state_d = (FAST_ALU != 0) ? WB_AUIPC : EX_AUIPC;
          OPC_LOAD:   state_d = EX_LOAD;
          OPC_STORE:  state_d = EX_STORE;
          OPC_JAL:    state_d = EX_JAL;
          OPC_JALR:   state_d = EX_JALR;
          OPC_BRANCH: state_d = EX_BRANCH;
          default: begin
            state_d       = TRAP;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      // EX states preset the muxes of their WB state with enables held low
      EX_ALU:    begin rf_sel_s = RFSEL_ALU; state_d = WB_ALU; end
      EX_ALUI:   begin rf_sel_s = RFSEL_ALU; ula2_s = 1'b1; state_d = WB_ALUI; end
      EX_LUI:    begin rf_sel_s = RFSEL_IMM; state_d = WB_LUI; end
      EX_AUIPC:  begin rf_sel_s = RFSEL_ADDER; pc_adder_s = 1'b1; state_d = WB_AUIPC; end
      EX_JAL:    begin rf_sel_s = RFSEL_PC4; pc_next_s = 1'b1; pc_adder_s = 1'b1; state_d = WB_JAL; end
      EX_JALR:   begin rf_sel_s = RFSEL_PC4; pc_next_s = 1'b1; state_d = WB_JALR; end
      EX_BRANCH: begin branch_s = 1'b1; state_d = WB_BRANCH; end
      WB_ALU:    begin we_rf_s = 1'b1; load_pc_s = 1'b1; rf_sel_s = RFSEL_ALU; state_d = FETCH; end
      WB_ALUI: begin
        we_rf_s = 1'b1; load_pc_s = 1'b1; rf_sel_s = RFSEL_ALU; ula2_s = 1'b1; state_d = FETCH;
      end
      WB_LUI:    begin we_rf_s = 1'b1; load_pc_s = 1'b1; rf_sel_s = RFSEL_IMM; state_d = FETCH; end
      WB_AUIPC: begin
        we_rf_s = 1'b1; load_pc_s = 1'b1; rf_sel_s = RFSEL_ADDER; pc_adder_s = 1'b1; state_d = FETCH;
      end
      WB_JAL: begin
        we_rf_s = 1'b1; load_pc_s = 1'b1; rf_sel_s = RFSEL_PC4;
        pc_next_s = 1'b1; pc_adder_s = 1'b1; state_d = FETCH;
      end
      WB_JALR: begin
        we_rf_s = 1'b1; load_pc_s = 1'b1; rf_sel_s = RFSEL_PC4; pc_next_s = 1'b1; state_d = FETCH;
      end
      WB_BRANCH: begin branch_s = 1'b1; load_pc_s = 1'b1; state_d = FETCH; end
      EX_LOAD:   begin ula2_s = 1'b1; state_d = MEM_LOAD; end
      MEM_LOAD: begin
        mem_req_s = 1'b1;
        ula2_s    = 1'b1;
        rf_sel_s  = RFSEL_MEM;
        we_rf_s   = bus.mem_ready;
        load_pc_s = bus.mem_ready;
        if (bus.mem_ready) state_d = FETCH;
        else if (expire_s) state_d = TRAP;
        else               state_d = MEM_LOAD;
      end
      EX_STORE:  begin ula2_s = 1'b1; state_d = MEM_STORE; end
      MEM_STORE: begin
        mem_req_s = 1'b1;
        we_mem_s  = 1'b1;
        ula2_s    = 1'b1;
        load_pc_s = bus.mem_ready;
        if (bus.mem_ready) state_d = FETCH;
        else if (expire_s) state_d = TRAP;
        else               state_d = MEM_STORE;
      end
      TRAP:      state_d = TRAP;
      default: begin
        state_d       = TRAP;
        set_illegal_s = 1'b1;
      end
    endcase
  end

  assign illegal_d = illegal_q || set_illegal_s;
  assign timeout_d = timeout_q || expire_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Reset gates every output combinationally so a mid-access reset drops writes at once
  assign bus.mem_req       = mem_req_s  && !reset;
  assign bus.WE_RF         = we_rf_s    && !reset;
  assign bus.WE_MEM        = we_mem_s   && !reset;
  assign bus.ULA_din2_sel  = ula2_s     && !reset;
  assign bus.addr_sel      = addr_sel_s && !reset;
  assign bus.load_pc       = load_pc_s  && !reset;
  assign bus.load_ir       = load_ir_s  && !reset;
  assign bus.branch        = branch_s   && !reset;
  assign bus.pc_next_sel   = pc_next_s  && !reset;
  assign bus.pc_adder_sel  = pc_adder_s && !reset;
  assign bus.illegal_instr = illegal_q  && !reset;
  assign bus.timeout_err   = timeout_q  && !reset;
  assign bus.RF_din_sel    = reset ? 3'b000 : rf_sel_s;
  assign bus.state_dbg     = reset ? 5'd0 : state_q;

endmodule

// File: tb/tb_uc_mc_handshake.sv
// Directed bench: dut_a (MEM_TIMEOUT=4, FAST_ALU=0) and dut_b (default timeout, FAST_ALU=1).
module tb_uc_mc_handshake;
  import uc_pkg::*;

  // flag order: mem_req WE_RF WE_MEM ULA2 | addr_sel load_pc load_ir branch | pc_next pc_adder illegal timeout
  localparam logic [11:0] F_NONE = 12'b0000_0000_0000;
  localparam logic [11:0] F_FW   = 12'b1000_1000_0000;
  localparam logic [11:0] F_FR   = 12'b1000_1010_0000;
  localparam logic [11:0] F_EXI  = 12'b0001_0000_0000;
  localparam logic [11:0] F_WBI  = 12'b0101_0100_0000;
  localparam logic [11:0] F_MLW  = 12'b1001_0000_0000;
  localparam logic [11:0] F_MLR  = 12'b1101_0100_0000;
  localparam logic [11:0] F_MSW  = 12'b1011_0000_0000;
  localparam logic [11:0] F_MSR  = 12'b1011_0100_0000;
  localparam logic [11:0] F_ILL  = 12'b0000_0000_0010;
  localparam logic [11:0] F_TO   = 12'b0000_0000_0001;
  localparam logic [11:0] F_WBL  = 12'b0100_0100_0000;

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic        rst;
    state_e      st;
    logic [2:0]  rf;
    logic [11:0] fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;
  logic [19:0] obs_a, obs_b;
  vec_t tab[$];

  always #5 clk = ~clk;

  uc_mc_handshake_if if_a ();
  uc_mc_handshake_if if_b ();

  uc_mc_handshake #(.MEM_TIMEOUT(4), .FAST_ALU(0)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a.master));
  uc_mc_handshake #(.MEM_TIMEOUT(16), .FAST_ALU(1)) dut_b (.clk(clk), .reset(rst_b), .bus(if_b.master));

  assign obs_a = {if_a.state_dbg, if_a.RF_din_sel, if_a.mem_req, if_a.WE_RF, if_a.WE_MEM,
                  if_a.ULA_din2_sel, if_a.addr_sel, if_a.load_pc, if_a.load_ir, if_a.branch,
                  if_a.pc_next_sel, if_a.pc_adder_sel, if_a.illegal_instr, if_a.timeout_err};
  assign obs_b = {if_b.state_dbg, if_b.RF_din_sel, if_b.mem_req, if_b.WE_RF, if_b.WE_MEM,
                  if_b.ULA_din2_sel, if_b.addr_sel, if_b.load_pc, if_b.load_ir, if_b.branch,
                  if_b.pc_next_sel, if_b.pc_adder_sel, if_b.illegal_instr, if_b.timeout_err};

  task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s: got st=%0d rf=%b fl=%b, expected st=%0d rf=%b fl=%b",
               nm, got[19:15], got[14:12], got[11:0], exp_v[19:15], exp_v[14:12], exp_v[11:0]);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and check outputs 1 time unit later
  task automatic step(input bit sel, input string nm, input logic [6:0] op, input logic rdy,
                      input logic rst, input state_e st, input logic [2:0] rf, input logic [11:0] fl);
    @(negedge clk);
    if (!sel) begin
      if_a.opcode = op; if_a.mem_ready = rdy; rst_a = rst;
    end else begin
      if_b.opcode = op; if_b.mem_ready = rdy; rst_b = rst;
    end
    #1;
    chk(nm, sel ? obs_b : obs_a, {st, rf, fl});
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    if_a.opcode = 7'h00; if_a.mem_ready = 1'b0;
    if_b.opcode = 7'h00; if_b.mem_ready = 1'b0;

    // reset, ADDI, FETCH with 3 waits, LOAD with 2 waits, illegal opcode
    tab.push_back(vec_t'{7'h00, 1'b1, 1'b1, FETCH,    3'b000, F_NONE});
    tab.push_back(vec_t'{7'h13, 1'b1, 1'b0, FETCH,    3'b000, F_FR});
    tab.push_back(vec_t'{7'h13, 1'b1, 1'b0, DECODE,   3'b000, F_NONE});
    tab.push_back(vec_t'{7'h13, 1'b1, 1'b0, EX_ALUI,  3'b001, F_EXI});
    tab.push_back(vec_t'{7'h13, 1'b1, 1'b0, WB_ALUI,  3'b001, F_WBI});
    tab.push_back(vec_t'{7'h03, 1'b0, 1'b0, FETCH,    3'b000, F_FW});
    tab.push_back(vec_t'{7'h03, 1'b0, 1'b0, FETCH,    3'b000, F_FW});
    tab.push_back(vec_t'{7'h03, 1'b0, 1'b0, FETCH,    3'b000, F_FW});
    tab.push_back(vec_t'{7'h03, 1'b1, 1'b0, FETCH,    3'b000, F_FR});
    tab.push_back(vec_t'{7'h03, 1'b1, 1'b0, DECODE,   3'b000, F_NONE});
    tab.push_back(vec_t'{7'h03, 1'b0, 1'b0, EX_LOAD,  3'b000, F_EXI});
    tab.push_back(vec_t'{7'h03, 1'b0, 1'b0, MEM_LOAD, 3'b000, F_MLW});
    tab.push_back(vec_t'{7'h03, 1'b0, 1'b0, MEM_LOAD, 3'b000, F_MLW});
    tab.push_back(vec_t'{7'h03, 1'b1, 1'b0, MEM_LOAD, 3'b000, F_MLR});
    tab.push_back(vec_t'{7'h00, 1'b1, 1'b0, FETCH,    3'b000, F_FR});
    tab.push_back(vec_t'{7'h00, 1'b1, 1'b0, DECODE,   3'b000, F_NONE});
    tab.push_back(vec_t'{7'h00, 1'b1, 1'b0, TRAP,     3'b000, F_ILL});

    foreach (tab[i])
      step(1'b0, $sformatf("vec%0d", i), tab[i].op, tab[i].rdy, tab[i].rst, tab[i].st, tab[i].rf, tab[i].fl);

    for (int i = 0; i < 20; i++)
      step(1'b0, $sformatf("trap_hold%0d", i), 7'h00, 1'(i % 2), 1'b0, TRAP, 3'b000, F_ILL);
    step(1'b0, "trap_rst",  7'h23, 1'b1, 1'b1, FETCH, 3'b000, F_NONE);
    step(1'b0, "post_rst",  7'h23, 1'b1, 1'b0, FETCH, 3'b000, F_FR);

    // STORE timeout after exactly 4 wait cycles
    step(1'b0, "st_dec",    7'h23, 1'b1, 1'b0, DECODE,   3'b000, F_NONE);
    step(1'b0, "st_ex",     7'h23, 1'b0, 1'b0, EX_STORE, 3'b000, F_EXI);
    for (int i = 0; i < 4; i++)
      step(1'b0, $sformatf("st_wait%0d", i), 7'h23, 1'b0, 1'b0, MEM_STORE, 3'b000, F_MSW);
    step(1'b0, "st_trap",   7'h23, 1'b0, 1'b0, TRAP, 3'b000, F_TO);
    step(1'b0, "st_trap2",  7'h23, 1'b1, 1'b0, TRAP, 3'b000, F_TO);

    // STORE completing on the 4th wait cycle: ready beats the watchdog
    step(1'b0, "st2_rst",   7'h23, 1'b0, 1'b1, FETCH,    3'b000, F_NONE);
    step(1'b0, "st2_fetch", 7'h23, 1'b1, 1'b0, FETCH,    3'b000, F_FR);
    step(1'b0, "st2_dec",   7'h23, 1'b1, 1'b0, DECODE,   3'b000, F_NONE);
    step(1'b0, "st2_ex",    7'h23, 1'b0, 1'b0, EX_STORE, 3'b000, F_EXI);
    for (int i = 0; i < 3; i++)
      step(1'b0, $sformatf("st2_wait%0d", i), 7'h23, 1'b0, 1'b0, MEM_STORE, 3'b000, F_MSW);
    step(1'b0, "st2_ready", 7'h23, 1'b1, 1'b0, MEM_STORE, 3'b000, F_MSR);
    step(1'b0, "st2_done",  7'h23, 1'b1, 1'b0, FETCH,     3'b000, F_FR);

    // FAST_ALU LUI in 3 cycles, then reset in the middle of a store
    step(1'b1, "b_rst",     7'h37, 1'b1, 1'b1, FETCH,  3'b000, F_NONE);
    step(1'b1, "b_fetch",   7'h37, 1'b1, 1'b0, FETCH,  3'b000, F_FR);
    step(1'b1, "b_dec",     7'h37, 1'b1, 1'b0, DECODE, 3'b000, F_NONE);
    step(1'b1, "b_wb_lui",  7'h37, 1'b1, 1'b0, WB_LUI, 3'b100, F_WBL);
    step(1'b1, "b_fetch2",  7'h23, 1'b1, 1'b0, FETCH,  3'b000, F_FR);
    step(1'b1, "b_dec2",    7'h23, 1'b1, 1'b0, DECODE, 3'b000, F_NONE);
    step(1'b1, "b_ex_st",   7'h23, 1'b0, 1'b0, EX_STORE,  3'b000, F_EXI);
    step(1'b1, "b_mem_st",  7'h23, 1'b0, 1'b0, MEM_STORE, 3'b000, F_MSW);
    #2;
    rst_b = 1'b1;
    #1;
    chk("b_midrst", obs_b, {FETCH, 3'b000, F_NONE});
    step(1'b1, "b_after",   7'h23, 1'b0, 1'b0, FETCH, 3'b000, F_FW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
